block_serial_subtractor: RTL and testbench



---
 rtl/block_serial_subtractor.sv | 158 +++++++++++++++
 tb/tb_block_serial_subtractor.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_serial_subtractor.sv
// block_serial_subtractor
// Multi-cycle unsigned subtractor: diff = (a - b - bin) mod 2^N, bout = (a < b + bin).
// One BLOCK_SIZE-bit slice is processed per clock, least-significant slice first.
// Inside a slice the borrow ripples bit by bit; when every bit of the slice
// propagates (a_i == b_i) the slice borrow-in is forwarded directly as the
// slice borrow-out (block-skip). Both paths give the same value.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands present          in_ready   block can accept operands
//   a, b, bin  minuend, subtrahend, borrow in
//   out_valid  diff/bout valid           out_ready  sink accepts result
//   diff       (a - b - bin) mod 2^N     bout       final borrow out
//   busy       high while an operation is in RUN or DONE
module block_serial_subtractor #(
  parameter int N          = 8,
  parameter int BLOCK_SIZE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         busy
);

  localparam int NB = (N + BLOCK_SIZE - 1) / BLOCK_SIZE;
  localparam int KW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NB - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic            r_br;
  logic [KW-1:0]   r_k;
  logic [N-1:0]    r_diff;
  logic            r_bout;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;

  logic [31:0]           w_shamt;
  logic [BLOCK_SIZE-1:0] w_a_sl;
  logic [BLOCK_SIZE-1:0] w_b_sl;
  logic [BLOCK_SIZE-1:0] w_d_sl;
  logic [BLOCK_SIZE-1:0] w_p_sl;
  logic [BLOCK_SIZE:0]   w_br;
  logic                  w_sl_bout;
  logic [N-1:0]          w_ins;

  // Borrow generated out of one bit position of a - b - br.
  function automatic logic borrow_next(input logic ai, input logic bi, input logic bri);
    return (~ai & bi) | (~(ai ^ bi) & bri);
  endfunction

  // Current slice: extract operands, ripple the borrow, pick skip or ripple borrow-out.
  // Bits beyond N shift in as zero; such bits have a_i == b_i == 0, so they
  // propagate the borrow unchanged and the partial last slice needs no special case.
  always_comb begin
    w_shamt = 32'(r_k) * 32'(BLOCK_SIZE);
    w_a_sl  = BLOCK_SIZE'(r_a >> w_shamt);
    w_b_sl  = BLOCK_SIZE'(r_b >> w_shamt);
    w_br    = {(BLOCK_SIZE + 1){1'b0}};
    w_d_sl  = {BLOCK_SIZE{1'b0}};
    w_p_sl  = {BLOCK_SIZE{1'b0}};
    w_br[0] = r_br;
    for (int j = 0; j < BLOCK_SIZE; j++) begin
      w_d_sl[j]   = w_a_sl[j] ^ w_b_sl[j] ^ w_br[j];
      w_p_sl[j]   = ~(w_a_sl[j] ^ w_b_sl[j]);
      w_br[j + 1] = borrow_next(w_a_sl[j], w_b_sl[j], w_br[j]);
    end
    if (&w_p_sl) begin
      w_sl_bout = r_br;
    end else begin
      w_sl_bout = w_br[BLOCK_SIZE];
    end
    // Slice bits placed at their position; anything above N is dropped by the cast.
    w_ins = N'({{N{1'b0}}, w_d_sl} << w_shamt);
  end

  // Control FSM with registered handshake outputs and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_a         <= {N{1'b0}};
      r_b         <= {N{1'b0}};
      r_br        <= 1'b0;
      r_k         <= {KW{1'b0}};
      r_diff      <= {N{1'b0}};
      r_bout      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= b;
            r_br       <= bin;
            r_k        <= {KW{1'b0}};
            r_diff     <= {N{1'b0}};
            r_bout     <= 1'b0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          // diff was cleared on accept, so OR-ing in each slice leaves uncomputed bits at 0.
          r_diff <= r_diff | w_ins;
          r_br   <= w_sl_bout;
          if (r_k == K_LAST) begin
            r_bout      <= w_sl_bout;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_k <= r_k + {{(KW - 1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign busy      = r_busy;

endmodule

// File: tb/tb_block_serial_subtractor.sv
// Testbench for block_serial_subtractor: three instances (N,BS) = (8,4), (5,2), (8,1)
// share clock and reset. Stimulus pushes hand-computed expected results into a
// per-instance queue; per-instance monitors pop and compare on each handshake.
module tb_block_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic        bo;
  } exp_t;

  exp_t q8[$];
  exp_t q5[$];
  exp_t q1[$];

  int total = 0;
  int bad   = 0;

  // instance 0: N=8, BS=4
  logic       p8_in_valid, p8_in_ready, p8_bin, p8_out_valid, p8_out_ready, p8_bout, p8_busy;
  logic [7:0] p8_a, p8_b, p8_diff;
  // instance 1: N=5, BS=2
  logic       p5_in_valid, p5_in_ready, p5_bin, p5_out_valid, p5_out_ready, p5_bout, p5_busy;
  logic [4:0] p5_a, p5_b, p5_diff;
  // instance 2: N=8, BS=1
  logic       p1_in_valid, p1_in_ready, p1_bin, p1_out_valid, p1_out_ready, p1_bout, p1_busy;
  logic [7:0] p1_a, p1_b, p1_diff;

  block_serial_subtractor #(.N(8), .BLOCK_SIZE(4)) u_p8 (
    .clk(clk), .rst_n(rst_n), .in_valid(p8_in_valid), .in_ready(p8_in_ready),
    .a(p8_a), .b(p8_b), .bin(p8_bin), .out_valid(p8_out_valid), .out_ready(p8_out_ready),
    .diff(p8_diff), .bout(p8_bout), .busy(p8_busy));

  block_serial_subtractor #(.N(5), .BLOCK_SIZE(2)) u_p5 (
    .clk(clk), .rst_n(rst_n), .in_valid(p5_in_valid), .in_ready(p5_in_ready),
    .a(p5_a), .b(p5_b), .bin(p5_bin), .out_valid(p5_out_valid), .out_ready(p5_out_ready),
    .diff(p5_diff), .bout(p5_bout), .busy(p5_busy));

  block_serial_subtractor #(.N(8), .BLOCK_SIZE(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .in_valid(p1_in_valid), .in_ready(p1_in_ready),
    .a(p1_a), .b(p1_b), .bin(p1_bin), .out_valid(p1_out_valid), .out_ready(p1_out_ready),
    .diff(p1_diff), .bout(p1_bout), .busy(p1_busy));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic rdy(input int sel);
    case (sel)
      0:       return p8_in_ready;
      1:       return p5_in_ready;
      default: return p1_in_ready;
    endcase
  endfunction

  // Called 1 time unit after a rising edge; returns 1 time unit after the accept edge.
  task automatic issue(input int sel, input logic [15:0] ia, input logic [15:0] ib,
                       input logic ibin, input logic [15:0] ed, input logic ebo, input bit push);
    int   n;
    exp_t e;
    n = 0;
    while (!rdy(sel) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", {31'd0, rdy(sel)}, 32'd1);
    e.d  = ed;
    e.bo = ebo;
    case (sel)
      0: begin
        p8_a = ia[7:0]; p8_b = ib[7:0]; p8_bin = ibin; p8_in_valid = 1'b1;
        if (push) q8.push_back(e);
      end
      1: begin
        p5_a = ia[4:0]; p5_b = ib[4:0]; p5_bin = ibin; p5_in_valid = 1'b1;
        if (push) q5.push_back(e);
      end
      default: begin
        p1_a = ia[7:0]; p1_b = ib[7:0]; p1_bin = ibin; p1_in_valid = 1'b1;
        if (push) q1.push_back(e);
      end
    endcase
    @(posedge clk); #1;
    p8_in_valid = 1'b0;
    p5_in_valid = 1'b0;
    p1_in_valid = 1'b0;
  endtask

  exp_t m8, m5, m1;

  // Monitor for the N=8,BS=4 instance.
  always @(negedge clk) begin
    if (rst_n && p8_out_valid && p8_out_ready) begin
      if (q8.size() == 0) begin
        total++; bad++;
        $display("FAIL p8_unexpected_result: got diff=%0h with nothing expected", p8_diff);
      end else begin
        m8 = q8.pop_front();
        check("p8_diff", {24'd0, p8_diff}, {16'd0, m8.d});
        check("p8_bout", {31'd0, p8_bout}, {31'd0, m8.bo});
      end
    end
  end

  // Monitor for the N=5,BS=2 instance.
  always @(negedge clk) begin
    if (rst_n && p5_out_valid && p5_out_ready) begin
      if (q5.size() == 0) begin
        total++; bad++;
        $display("FAIL p5_unexpected_result: got diff=%0h with nothing expected", p5_diff);
      end else begin
        m5 = q5.pop_front();
        check("p5_diff", {27'd0, p5_diff}, {16'd0, m5.d});
        check("p5_bout", {31'd0, p5_bout}, {31'd0, m5.bo});
      end
    end
  end

  // Monitor for the N=8,BS=1 instance.
  always @(negedge clk) begin
    if (rst_n && p1_out_valid && p1_out_ready) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL p1_unexpected_result: got diff=%0h with nothing expected", p1_diff);
      end else begin
        m1 = q1.pop_front();
        check("p1_diff", {24'd0, p1_diff}, {16'd0, m1.d});
        check("p1_bout", {31'd0, p1_bout}, {31'd0, m1.bo});
      end
    end
  end

  // Sink stall pattern for the N=5 instance: ready two cycles out of three.
  initial begin
    int cyc;
    cyc = 0;
    p5_out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      p5_out_ready = ((cyc % 3) != 0);
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    p8_in_valid = 1'b0; p8_a = 8'h00; p8_b = 8'h00; p8_bin = 1'b0; p8_out_ready = 1'b1;
    p5_in_valid = 1'b0; p5_a = 5'h00; p5_b = 5'h00; p5_bin = 1'b0;
    p1_in_valid = 1'b0; p1_a = 8'h00; p1_b = 8'h00; p1_bin = 1'b0; p1_out_ready = 1'b1;
    #12;
    check("rst_in_ready",  {31'd0, p8_in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, p8_out_valid}, 32'd0);
    check("rst_busy",      {31'd0, p8_busy}, 32'd0);
    check("rst_diff",      {24'd0, p8_diff}, 32'd0);
    check("rst_bout",      {31'd0, p8_bout}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: accept at T0, out_valid after T0+2, one-cycle result with out_ready high.
    issue(0, 16'h00, 16'h01, 1'b0, 16'hFF, 1'b1, 1'b1);
    check("lat_busy",      {31'd0, p8_busy}, 32'd1);
    check("lat_in_ready0", {31'd0, p8_in_ready}, 32'd0);
    @(posedge clk); #1;
    check("lat_valid_t1",  {31'd0, p8_out_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_valid_t2",  {31'd0, p8_out_valid}, 32'd1);
    @(posedge clk); #1;
    check("lat_valid_t3",  {31'd0, p8_out_valid}, 32'd0);
    check("lat_in_ready3", {31'd0, p8_in_ready}, 32'd1);

    // Fully propagating slices (skip path) and other N=8,BS=4 vectors.
    issue(0, 16'h5A, 16'h5A, 1'b1, 16'hFF, 1'b1, 1'b1);
    issue(0, 16'h5A, 16'h5A, 1'b0, 16'h00, 1'b0, 1'b1);
    issue(0, 16'hFF, 16'h00, 1'b1, 16'hFE, 1'b0, 1'b1);
    issue(0, 16'h80, 16'h7F, 1'b1, 16'h00, 1'b0, 1'b1);
    issue(0, 16'h00, 16'hFF, 1'b1, 16'h00, 1'b1, 1'b1);

    // Stall: out_ready low for 5 cycles with a competing in_valid.
    n = 0;
    while (p8_busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    p8_out_ready = 1'b0;
    issue(0, 16'hC8, 16'h37, 1'b0, 16'h91, 1'b0, 1'b1);
    n = 0;
    while (!p8_out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_valid_seen", {31'd0, p8_out_valid}, 32'd1);
    p8_a = 8'h11; p8_b = 8'h01; p8_bin = 1'b0; p8_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid",    {31'd0, p8_out_valid}, 32'd1);
      check("stall_diff",     {24'd0, p8_diff}, 32'h91);
      check("stall_in_ready", {31'd0, p8_in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    p8_in_valid  = 1'b0;
    p8_out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release_valid", {31'd0, p8_out_valid}, 32'd0);
    check("stall_release_ready", {31'd0, p8_in_ready}, 32'd1);

    // Partial last slice, N=5 BS=2 (latency 3 cycles).
    n = 0;
    while (!p5_out_ready && n < 5) begin
      @(posedge clk); #1;
      n++;
    end
    issue(1, 16'h10, 16'h03, 1'b0, 16'h0D, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("p5_lat_t2", {31'd0, p5_out_valid}, 32'd0);
    @(posedge clk); #1;
    check("p5_lat_t3", {31'd0, p5_out_valid}, 32'd1);
    issue(1, 16'h00, 16'h1F, 1'b1, 16'h00, 1'b1, 1'b1);
    issue(1, 16'h1F, 16'h01, 1'b1, 16'h1D, 1'b0, 1'b1);
    issue(1, 16'h05, 16'h06, 1'b0, 16'h1F, 1'b1, 1'b1);
    issue(1, 16'h15, 16'h0A, 1'b0, 16'h0B, 1'b0, 1'b1);

    // Let everything drain before pulling reset.
    n = 0;
    while ((q8.size() != 0 || q5.size() != 0 || p5_busy) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end

    // Reset mid-RUN on the N=8,BS=1 instance: 3 slices done at reset time.
    issue(2, 16'hFF, 16'h00, 1'b0, 16'hFF, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("mid_partial_diff", {24'd0, p1_diff}, 32'h07);
    check("mid_busy",         {31'd0, p1_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, p1_out_valid}, 32'd0);
    check("arst_busy",      {31'd0, p1_busy}, 32'd0);
    check("arst_diff",      {24'd0, p1_diff}, 32'd0);
    check("arst_bout",      {31'd0, p1_bout}, 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", {31'd0, p1_in_ready}, 32'd1);
    issue(2, 16'h03, 16'h01, 1'b0, 16'h02, 1'b0, 1'b1);
    repeat (7) begin
      @(posedge clk); #1;
    end
    check("p1_lat_t7", {31'd0, p1_out_valid}, 32'd0);
    @(posedge clk); #1;
    check("p1_lat_t8", {31'd0, p1_out_valid}, 32'd1);
    issue(2, 16'hA5, 16'h5A, 1'b0, 16'h4B, 1'b0, 1'b1);
    issue(2, 16'h10, 16'h20, 1'b1, 16'hEF, 1'b1, 1'b1);

    // Drain and make sure nothing was dropped.
    n = 0;
    while ((q8.size() != 0 || q5.size() != 0 || q1.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("q8_drained", q8.size(), 32'd0);
    check("q5_drained", q5.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
